traffic_display_scan: RTL

//  Downstream of traffic_light: consumes its four BCD countdown digits
//  (A_Time_L/H, B_Time_L/H) and A_light/B_light, drives a 4-digit multiplexed
//  7-segment display. One digit is enabled at a time, round-robin. Inputs are

---
 rtl/traffic_display_scan.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/traffic_display_scan.sv
// Four-digit multiplexed 7-segment scanner for the traffic_light countdowns.
// Optional expiry blink is compiled in with `define TRAFFIC_DISPLAY_BLINK_EN.
module traffic_display_scan #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
`ifdef TRAFFIC_DISPLAY_BLINK_EN
    ,
    parameter int BLINK_DIV      = 16,
    parameter int BLINK_THRESH   = 3
`endif
) (
    input  logic       Clk,
    input  logic       R,
    input  logic [0:3] A_Time_L,
    input  logic [0:3] A_Time_H,
    input  logic [0:3] B_Time_L,
    input  logic [0:3] B_Time_H,
    input  logic       A_light,
    input  logic       B_light,
    output logic [0:6] Seg,
    output logic       Dp,
    output logic [0:3] An,
    output logic       Frame
);

    localparam int         CW      = $clog2(REFRESH_DIV);
    localparam logic [0:6] SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_digit;
    logic [0:3]    r_sh_al, r_sh_ah, r_sh_bl, r_sh_bh;
    logic          r_sh_la, r_sh_lb;
    logic [0:3]    r_an;
    logic [0:6]    r_seg;
    logic          r_dp;
    logic          r_frame;

    logic          w_tick, w_load, w_blank, w_hide, w_dp_lit;
    logic [1:0]    w_next_digit;
    logic [0:3]    w_al, w_ah, w_bl, w_bh, w_val;
    logic          w_la, w_lb;
    logic [0:6]    w_lit;
    logic [0:3]    w_an_next;

    function automatic logic [0:6] f_decode(input logic [0:3] v);
        case (v)
            4'd0:    f_decode = 7'b1111110;
            4'd1:    f_decode = 7'b0110000;
            4'd2:    f_decode = 7'b1101101;
            4'd3:    f_decode = 7'b1111001;
            4'd4:    f_decode = 7'b0110011;
            4'd5:    f_decode = 7'b1011011;
            4'd6:    f_decode = 7'b1011111;
            4'd7:    f_decode = 7'b1110000;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1111011;
            default: f_decode = 7'b0000001;
        endcase
    endfunction

    assign w_tick       = (r_cnt == CW'(REFRESH_DIV - 1));
    assign w_load       = w_tick && (r_digit == 2'd3);
    assign w_next_digit = r_digit + 1'b1;

    // Digit 0 of a new frame must show the values captured on this same edge.
    assign w_al = w_load ? A_Time_L : r_sh_al;
    assign w_ah = w_load ? A_Time_H : r_sh_ah;
    assign w_bl = w_load ? B_Time_L : r_sh_bl;
    assign w_bh = w_load ? B_Time_H : r_sh_bh;
    assign w_la = w_load ? A_light  : r_sh_la;
    assign w_lb = w_load ? B_light  : r_sh_lb;

    always_comb begin
        w_val = w_al;
        case (w_next_digit)
            2'd0: w_val = w_al;
            2'd1: w_val = w_ah;
            2'd2: w_val = w_bl;
            2'd3: w_val = w_bh;
            default: w_val = w_al;
        endcase
    end

    assign w_lit    = f_decode(w_val);
    assign w_blank  = w_next_digit[0] && (w_val == 4'd0);
    assign w_dp_lit = ((w_next_digit == 2'd0) && w_la) || ((w_next_digit == 2'd2) && w_lb);

`ifdef TRAFFIC_DISPLAY_BLINK_EN
    localparam int         BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [3:0] THR = 4'(BLINK_THRESH);

    logic          r_phase;
    logic [BW-1:0] r_fcnt;
    logic          r_off_a, r_off_b;
    logic          w_off_a_now, w_off_b_now, w_off_a, w_off_b;

    assign w_off_a_now = !r_phase && w_la && (w_ah == 4'd0) && (w_al <= THR);
    assign w_off_b_now = !r_phase && w_lb && (w_bh == 4'd0) && (w_bl <= THR);
    assign w_off_a     = w_load ? w_off_a_now : r_off_a;
    assign w_off_b     = w_load ? w_off_b_now : r_off_b;
    assign w_hide      = w_blank || (w_next_digit[1] ? w_off_b : w_off_a);

    always_ff @(posedge Clk) begin
        if (R) begin
            r_phase <= 1'b1;
            r_fcnt  <= '0;
            r_off_a <= 1'b0;
            r_off_b <= 1'b0;
        end else begin
            if (w_load) begin
                r_off_a <= w_off_a_now;
                r_off_b <= w_off_b_now;
            end
            // Phase advances on the Frame cycle; blanking is latched per frame above.
            if (r_frame) begin
                if (r_fcnt == BW'(BLINK_DIV - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt  <= r_fcnt + 1'b1;
                end
            end
        end
    end
`else
    assign w_hide = w_blank;
`endif

    always_comb begin
        w_an_next = '1;
        if (!w_hide) w_an_next[w_next_digit] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (R) begin
            r_cnt   <= '0;
            r_digit <= 2'd3;
            r_sh_al <= '0;
            r_sh_ah <= '0;
            r_sh_bl <= '0;
            r_sh_bh <= '0;
            r_sh_la <= 1'b0;
            r_sh_lb <= 1'b0;
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= SEG_ACTIVE_LOW;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_frame <= w_load;
            if (w_tick) begin
                r_digit <= w_next_digit;
                r_an    <= w_an_next;
                r_seg   <= SEG_ACTIVE_LOW ? ~w_lit : w_lit;
                r_dp    <= SEG_ACTIVE_LOW ? ~w_dp_lit : w_dp_lit;
            end
            if (w_load) begin
                r_sh_al <= A_Time_L;
                r_sh_ah <= A_Time_H;
                r_sh_bl <= B_Time_L;
                r_sh_bh <= B_Time_H;
                r_sh_la <= A_light;
                r_sh_lb <= B_light;
            end
        end
    end

    assign Seg   = r_seg;
    assign Dp    = r_dp;
    assign An    = r_an;
    assign Frame = r_frame;

endmodule
